// File: rtl/sram_wrr_arbiter_if.sv
// Requester-side bus of the SRAM weighted round-robin arbiter.
// master = the requesters, slave = the arbiter.
interface sram_wrr_arbiter_if #(
  parameter int NUM_CH          = 4,
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_DATA_WIDTH = 36
);
  logic [NUM_CH-1:0]                 req;
  logic [NUM_CH-1:0]                 rd_wr_L;
  logic [NUM_CH*SRAM_ADDR_WIDTH-1:0] addr;
  logic [NUM_CH*SRAM_DATA_WIDTH-1:0] wr_data;
  logic [NUM_CH-1:0]                 ack;
  logic [SRAM_DATA_WIDTH-1:0]        rd_data;
  logic [NUM_CH-1:0]                 rd_vld;

  modport master (
    output req, rd_wr_L, addr, wr_data,
    input  ack, rd_data, rd_vld
  );

  modport slave (
    input  req, rd_wr_L, addr, wr_data,
    output ack, rd_data, rd_vld
  );
endinterface

// File: rtl/sram_wrr_arbiter.sv
// N-channel weighted round-robin arbiter in front of a single-port ZBT SRAM.
// One accept per cycle; the SRAM command is registered one cycle after the
// accept, write data follows WR_DATA_LATENCY cycles later and read data is
// steered back to its channel by a tag pipeline.
//
// state | meaning
// IDLE  | no channel owns the bus; search starts at r_ptr
// SERVE | channel r_ptr owns the bus while it requests and has credit
module sram_wrr_arbiter #(
  parameter int NUM_CH          = 4,
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_DATA_WIDTH = 36,
  parameter int WEIGHT_WIDTH    = 4,
  parameter int RD_LATENCY      = 4,
  parameter int WR_DATA_LATENCY = 2
) (
  input  logic                              clk,
  input  logic                              reset_L,
  input  logic [NUM_CH*WEIGHT_WIDTH-1:0]    weights,
  sram_wrr_arbiter_if.slave                 bus,
  output logic [SRAM_ADDR_WIDTH-1:0]        sram_addr,
  output logic                              sram_we,
  output logic [SRAM_DATA_WIDTH/9-1:0]      sram_bw,
  output logic [SRAM_DATA_WIDTH-1:0]        sram_wr_data,
  input  logic [SRAM_DATA_WIDTH-1:0]        sram_rd_data,
  output logic                              sram_tri_en
);
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW = SRAM_DATA_WIDTH / 9;
  localparam logic [WEIGHT_WIDTH-1:0] ONE_W = 1;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t                      r_state, w_state_nxt;
  logic [PW-1:0]               r_ptr, w_ptr_nxt, w_sel, w_gnt;
  logic [WEIGHT_WIDTH-1:0]     r_credit, w_credit_nxt, w_sel_weight;
  logic                        w_found, w_accept;
  logic [NUM_CH-1:0]           w_ack;
  logic                        w_gnt_rd;
  logic [SRAM_ADDR_WIDTH-1:0]  w_gnt_addr;
  logic [SRAM_DATA_WIDTH-1:0]  w_gnt_wdata;

  logic [SRAM_ADDR_WIDTH-1:0]  r_sram_addr;
  logic                        r_sram_we;
  logic [BW-1:0]               r_sram_bw;
  logic [SRAM_DATA_WIDTH-1:0]  r_sram_wr_data;
  logic                        r_sram_tri_en;
  logic [SRAM_DATA_WIDTH-1:0]  r_rd_data;
  logic [NUM_CH-1:0]           r_rd_vld;

  logic [RD_LATENCY-1:0]       r_tag_vld;
  logic [PW-1:0]               r_tag_ch [RD_LATENCY];
  logic [WR_DATA_LATENCY-1:0]  r_wd_vld;
  logic [SRAM_DATA_WIDTH-1:0]  r_wd_data [WR_DATA_LATENCY];

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return s[PW-1:0];
  endfunction

  // Find the next requester: IDLE looks at ptr first, SERVE looks at the
  // other channels first and only falls back to ptr when it is alone.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    for (int k = 0; k <= NUM_CH; k++) begin
      if (!w_found && (k > 0 || r_state == IDLE) && (k < NUM_CH || r_state == SERVE)
          && bus.req[wrap_add(r_ptr, k)]) begin
        w_found = 1'b1;
        w_sel   = wrap_add(r_ptr, k);
      end
    end
  end

  assign w_sel_weight = weights[int'(w_sel)*WEIGHT_WIDTH +: WEIGHT_WIDTH];

  // Next state, pointer, credit and the accept decision.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_credit_nxt = r_credit;
    w_accept     = 1'b0;
    w_gnt        = r_ptr;
    if (reset_L) begin
      if (r_state == SERVE && bus.req[r_ptr] && r_credit != '0) begin
        w_accept     = 1'b1;
        w_credit_nxt = r_credit - ONE_W;
      end else if (w_found) begin
        w_accept     = 1'b1;
        w_gnt        = w_sel;
        w_ptr_nxt    = w_sel;
        w_state_nxt  = SERVE;
        // a zero weight behaves as one, so the reload leaves zero credit
        w_credit_nxt = (w_sel_weight == '0) ? '0 : w_sel_weight - ONE_W;
      end else begin
        w_state_nxt = IDLE;
        if (r_state == SERVE) w_ptr_nxt = wrap_add(r_ptr, 1);
      end
    end
  end

  // One-hot accept strobe back to the requesters.
  always_comb begin
    w_ack        = '0;
    w_ack[w_gnt] = w_accept;
  end

  assign bus.ack     = w_ack;
  assign w_gnt_rd    = bus.rd_wr_L[w_gnt];
  assign w_gnt_addr  = bus.addr[int'(w_gnt)*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
  assign w_gnt_wdata = bus.wr_data[int'(w_gnt)*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_credit <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_credit <= w_credit_nxt;
    end
  end

  // SRAM command, write-data pipeline and read-tag pipeline.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_sram_addr    <= '0;
      r_sram_we      <= 1'b1;
      r_sram_bw      <= '1;
      r_sram_wr_data <= '0;
      r_sram_tri_en  <= 1'b0;
      r_rd_data      <= '0;
      r_rd_vld       <= '0;
      r_tag_vld      <= '0;
      r_wd_vld       <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_tag_ch[i] <= '0;
      for (int i = 0; i < WR_DATA_LATENCY; i++) r_wd_data[i] <= '0;
    end else begin
      r_sram_we <= !(w_accept && !w_gnt_rd);
      r_sram_bw <= (w_accept && !w_gnt_rd) ? '0 : '1;
      if (w_accept) r_sram_addr <= w_gnt_addr;

      r_tag_vld[0] <= w_accept && w_gnt_rd;
      r_tag_ch[0]  <= w_gnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_ch[i]  <= r_tag_ch[i-1];
      end

      r_wd_vld[0]  <= w_accept && !w_gnt_rd;
      r_wd_data[0] <= w_gnt_wdata;
      for (int i = 1; i < WR_DATA_LATENCY; i++) begin
        r_wd_vld[i]  <= r_wd_vld[i-1];
        r_wd_data[i] <= r_wd_data[i-1];
      end

      r_sram_tri_en <= r_wd_vld[WR_DATA_LATENCY-1];
      if (r_wd_vld[WR_DATA_LATENCY-1]) r_sram_wr_data <= r_wd_data[WR_DATA_LATENCY-1];

      r_rd_vld <= '0;
      if (r_tag_vld[RD_LATENCY-1]) begin
        r_rd_vld[r_tag_ch[RD_LATENCY-1]] <= 1'b1;
        r_rd_data                        <= sram_rd_data;
      end
    end
  end

  assign sram_addr    = r_sram_addr;
  assign sram_we      = r_sram_we;
  assign sram_bw      = r_sram_bw;
  assign sram_wr_data = r_sram_wr_data;
  assign sram_tri_en  = r_sram_tri_en;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_vld   = r_rd_vld;
endmodule

// File: tb/tb_sram_wrr_arbiter.sv
// Bench for sram_wrr_arbiter: vector table, directed timing sequences and
// a randomized run against a cycle-level reference model of the arbiter.
module tb_sram_wrr_arbiter;
  localparam int NCH = 4;
  localparam int AW  = 19;
  localparam int DW  = 36;
  localparam int WW  = 4;
  localparam int RDL = 4;
  localparam int WDL = 2;

  logic            clk = 1'b0;
  logic            reset_L;
  logic [NCH*WW-1:0] weights;
  logic [AW-1:0]   sram_addr;
  logic            sram_we;
  logic [DW/9-1:0] sram_bw;
  logic [DW-1:0]   sram_wr_data;
  logic [DW-1:0]   sram_rd_data;
  logic            sram_tri_en;

  always #5 clk = ~clk;

  sram_wrr_arbiter_if #(.NUM_CH(NCH), .SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW)) bus ();

  sram_wrr_arbiter #(
    .NUM_CH(NCH), .SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW),
    .WEIGHT_WIDTH(WW), .RD_LATENCY(RDL), .WR_DATA_LATENCY(WDL)
  ) dut (
    .clk(clk), .reset_L(reset_L), .weights(weights), .bus(bus),
    .sram_addr(sram_addr), .sram_we(sram_we), .sram_bw(sram_bw),
    .sram_wr_data(sram_wr_data), .sram_rd_data(sram_rd_data), .sram_tri_en(sram_tri_en)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // requester state
  bit          ch_req [NCH];
  bit          ch_rd  [NCH];
  logic [AW-1:0] ch_addr [NCH];
  logic [DW-1:0] ch_wd   [NCH];
  int          last_grant = -1;

  // reference model
  bit          m_serving;
  int          m_cur, m_credit;
  bit          e_cmd [64];
  bit          e_we  [64];
  logic [AW-1:0] e_addr [64];
  bit          e_tri [64];
  logic [DW-1:0] e_wd  [64];
  logic [NCH-1:0] e_vld [64];
  logic [DW-1:0] e_rd  [64];
  logic [AW-1:0] m_last_addr;
  logic [AW-1:0] pin_hist [64];

  // snapshots of the last sampled cycle
  logic [NCH-1:0] s_ack, s_vld;
  logic [AW-1:0]  s_addr;
  logic           s_we, s_tri;
  logic [DW/9-1:0] s_bw;
  logic [DW-1:0]  s_wd, s_rd;

  typedef struct {
    bit            rst_n;
    logic [NCH-1:0] req;
    logic [NCH-1:0] rd;
    logic [NCH*WW-1:0] w;
    logic [NCH-1:0] ack;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] f_mem(input logic [AW-1:0] a);
    if (a == 19'h1234) return 36'hABCDEF012;
    return {a[16:0] ^ 17'h1A5A5, a};
  endfunction

  function automatic int eff_w(input int ch);
    int w;
    w = int'(weights[ch*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic clear_slots();
    for (int i = 0; i < 64; i++) begin
      e_cmd[i] = 0; e_we[i] = 1; e_addr[i] = '0; e_tri[i] = 0;
      e_wd[i] = '0; e_vld[i] = '0; e_rd[i] = '0;
    end
  endtask

  task automatic apply_bus();
    for (int c = 0; c < NCH; c++) begin
      bus.req[c]                = ch_req[c];
      bus.rd_wr_L[c]            = ch_rd[c];
      bus.addr[c*AW +: AW]      = ch_addr[c];
      bus.wr_data[c*DW +: DW]   = ch_wd[c];
    end
  endtask

  task automatic new_op(input int c);
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    ch_req[c]  = 1;
    ch_rd[c]   = 1'($urandom_range(0, 1));
    ch_addr[c] = 19'($urandom());
    ch_wd[c]   = t[DW-1:0];
  endtask

  // One clock cycle: check at the falling edge, advance the model at the
  // rising edge, then present the SRAM read data for the new cycle.
  task automatic step();
    int g, n_cur, n_credit, slot, c;
    bit n_serving;
    logic [NCH-1:0] exp_ack;
    @(negedge clk);
    slot = cyc & 63;
    g = -1; n_cur = m_cur; n_credit = m_credit; n_serving = m_serving;
    if (reset_L) begin
      if (m_serving && bus.req[m_cur] && m_credit > 0) begin
        g = m_cur;
        n_credit = m_credit - 1;
      end else begin
        for (int k = 0; k < NCH; k++) begin
          c = m_serving ? (m_cur + 1 + k) % NCH : (m_cur + k) % NCH;
          if (g < 0 && bus.req[c]) g = c;
        end
        if (g >= 0) begin
          n_cur = g; n_credit = eff_w(g) - 1; n_serving = 1;
        end else begin
          n_serving = 0;
          if (m_serving) n_cur = (m_cur + 1) % NCH;
        end
      end
    end
    exp_ack = '0;
    if (g >= 0) exp_ack[g] = 1'b1;

    s_ack = bus.ack; s_vld = bus.rd_vld; s_rd = bus.rd_data;
    s_addr = sram_addr; s_we = sram_we; s_bw = sram_bw; s_tri = sram_tri_en; s_wd = sram_wr_data;

    chk("ack", s_ack, exp_ack);
    if (e_cmd[slot]) m_last_addr = e_addr[slot];
    chk("sram_we", s_we, (e_cmd[slot] && !e_we[slot]) ? 0 : 1);
    chk("sram_bw", s_bw, (e_cmd[slot] && !e_we[slot]) ? 0 : 4'hF);
    chk("sram_addr", s_addr, m_last_addr);
    chk("sram_tri_en", s_tri, e_tri[slot]);
    if (e_tri[slot]) chk("sram_wr_data", s_wd, e_wd[slot]);
    chk("rd_vld", s_vld, e_vld[slot]);
    if (e_vld[slot] != '0) chk("rd_data", s_rd, e_rd[slot]);
    pin_hist[slot] = s_addr;

    e_cmd[slot] = 0; e_we[slot] = 1; e_tri[slot] = 0; e_vld[slot] = '0;

    if (g >= 0) begin
      e_cmd[(cyc + 1) & 63]  = 1;
      e_we[(cyc + 1) & 63]   = ch_rd[g];
      e_addr[(cyc + 1) & 63] = ch_addr[g];
      if (ch_rd[g]) begin
        e_vld[(cyc + 1 + RDL) & 63][g] = 1'b1;
        e_rd[(cyc + 1 + RDL) & 63]     = f_mem(ch_addr[g]);
      end else begin
        e_tri[(cyc + 1 + WDL) & 63] = 1;
        e_wd[(cyc + 1 + WDL) & 63]  = ch_wd[g];
      end
    end
    last_grant = g;

    @(posedge clk);
    m_cur = n_cur; m_credit = n_credit; m_serving = n_serving;
    if (!reset_L) begin
      clear_slots();
      m_serving = 0; m_cur = 0; m_credit = 0; m_last_addr = '0;
    end
    cyc++;
    #1;
    sram_rd_data = f_mem(pin_hist[(cyc - (RDL - 1)) & 63]);
  endtask

  task automatic idle_all();
    for (int c = 0; c < NCH; c++) ch_req[c] = 0;
    apply_bus();
  endtask

  task automatic add_vec(input bit r, input logic [3:0] q, input logic [3:0] d,
                         input logic [15:0] w, input logic [3:0] a);
    vec_t v;
    v.rst_n = r; v.req = q; v.rd = d; v.w = w; v.ack = a;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0] share [7];
    logic [NCH-1:0] vld_or;
    share = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h4, 4'h4, 4'h8};

    for (int c = 0; c < NCH; c++) begin
      ch_req[c] = 0; ch_rd[c] = 0; ch_addr[c] = AW'(c + 1); ch_wd[c] = DW'(c + 16);
    end
    apply_bus();
    weights = 16'h1213;
    sram_rd_data = '0;
    reset_L = 0;
    for (int i = 0; i < 64; i++) pin_hist[i] = '0;
    clear_slots();
    m_serving = 0; m_cur = 0; m_credit = 0; m_last_addr = '0;
    @(posedge clk); #1;

    // vector table: reset with all requesting, weighted share, sole requester weight 0
    for (int i = 0; i < 3; i++) add_vec(0, 4'hF, 4'h0, 16'h1213, 4'h0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 7; i++) add_vec(1, 4'hF, 4'h0, 16'h1213, share[i]);
    for (int i = 0; i < 5; i++) add_vec(1, 4'h8, 4'h0, 16'h0213, 4'h8);

    for (int i = 0; i < tbl.size(); i++) begin
      reset_L = tbl[i].rst_n;
      weights = tbl[i].w;
      for (int c = 0; c < NCH; c++) begin
        ch_req[c] = tbl[i].req[c];
        ch_rd[c]  = tbl[i].rd[c];
      end
      apply_bus();
      step();
      chk("tbl_ack", s_ack, tbl[i].ack);
      if (last_grant >= 0) begin
        ch_addr[last_grant] = 19'($urandom());
        ch_wd[last_grant]   = DW'($urandom());
      end
    end

    // read latency: channel 2 reads 0x1234
    idle_all(); reset_L = 0; step(); reset_L = 1; step();
    ch_req[2] = 1; ch_rd[2] = 1; ch_addr[2] = 19'h1234; apply_bus();
    step(); chk("rd_ack", s_ack, 4'b0100);
    idle_all();
    step(); chk("rd_cmd_addr", s_addr, 19'h1234); chk("rd_cmd_we", s_we, 1);
    step(); step(); step();
    step(); chk("rd_vld_ch2", s_vld, 4'b0100); chk("rd_data_ch2", s_rd, 36'hABCDEF012);

    // write timing: channel 1 writes 0x55 to address 7
    ch_req[1] = 1; ch_rd[1] = 0; ch_addr[1] = 19'd7; ch_wd[1] = 36'h55; apply_bus();
    step(); chk("wr_ack", s_ack, 4'b0010);
    idle_all();
    step(); chk("wr_cmd_we", s_we, 0); chk("wr_cmd_bw", s_bw, 0); chk("wr_cmd_addr", s_addr, 7);
    step(); chk("wr_tri_early", s_tri, 0);
    step(); chk("wr_tri", s_tri, 1); chk("wr_data", s_wd, 36'h55);
    step(); chk("wr_tri_one_cycle", s_tri, 0);

    // reset in the middle of three outstanding reads
    reset_L = 0; step(); reset_L = 1;
    weights = 16'h1114;
    ch_req[0] = 1; ch_rd[0] = 1;
    for (int i = 0; i < 3; i++) begin
      ch_addr[0] = AW'(19'h100 + i); apply_bus();
      step(); chk("mid_rd_ack", s_ack, 4'b0001);
    end
    idle_all();
    step();
    reset_L = 0; step(); reset_L = 1;
    vld_or = '0;
    for (int i = 0; i < 8; i++) begin
      step(); vld_or |= s_vld;
    end
    chk("no_vld_after_reset", vld_or, 0);
    ch_req[1] = 1; ch_rd[1] = 1; ch_addr[1] = 19'h1234; apply_bus();
    step(); chk("post_rst_ack", s_ack, 4'b0010);
    idle_all();
    for (int i = 0; i < 4; i++) step();
    step(); chk("post_rst_vld", s_vld, 4'b0010); chk("post_rst_data", s_rd, 36'hABCDEF012);

    // randomized traffic with weight changes and occasional resets
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) weights = 16'($urandom());
      reset_L = ($urandom_range(0, 399) != 0);
      for (int c = 0; c < NCH; c++) begin
        if (c == last_grant) ch_req[c] = 0;
        if (!ch_req[c] && $urandom_range(0, 9) < 6) new_op(c);
      end
      apply_bus();
      step();
    end
    reset_L = 1;
    idle_all();
    for (int i = 0; i < 8; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
